uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Producer side of the UART programming write port.
- Assembles bytes from the UART byte receiver into 32-bit words and issues single-cycle write strobes with an auto-incrementing word address.
- Address bit ROM_DEPTH selects the target:
  - 0 = instruction memory, [0x0000, 0x3FFF] for ROM_DEPTH=14.
  - 1 = data memory, [0x4000, 0x7FFF].
- Drives the write-enable/address/data inputs of the instruction and data memories. Reports completion to hazard_unit.

Parameters:
- ROM_DEPTH, 14, word-address width of one memory; total address space is 2^(ROM_DEPTH+1) words.
- ISA_WIDTH, 32, word width; fixed at 4 bytes.
- TIMEOUT_CYCLES, 1000000, idle cycles after the last byte that end a session early.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  from hazard_unit. Level: UART load granted while high.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received byte.
- upg_wen  out  1  write strobe; feeds uart_write_enable.
- upg_adr  out  ROM_DEPTH+1  word address; feeds uart_addr.
- upg_dat  out  ISA_WIDTH  assembled word; feeds uart_data.
- upg_done  out  1  session complete; level.
- busy  out  1  high in RECV.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state, all outputs 0:
  - state=IDLE, byte_idx=0, timer=0, addr=0, upg_wen=0, upg_adr=0, upg_dat=0, upg_done=0, busy=0.
- States:
  - IDLE: start=1 -> RECV, with addr=0, byte_idx=0, timer=0.
  - RECV: see byte assembly, write strobe, timeout and abort rules below.
  - DONE: upg_done=1 held. start=0 -> IDLE. start=1 -> stays in DONE, no writes.
- Byte assembly:
  - Little-endian. byte_idx 0..3 writes bits [8*idx+7 : 8*idx] of a shadow word; byte_idx increments mod 4.
  - On capture of byte_idx=3, the next cycle drives upg_wen=1 for exactly one cycle.
  - That cycle: upg_dat = full word, upg_adr = addr.
  - Then addr increments.
  - upg_adr/upg_dat hold their last values between strobes.
- Write latency: 1 cycle from the 4th rx_valid to the upg_wen pulse.
- Back-to-back: an rx_valid in the upg_wen cycle is accepted as byte 0 of the next word. No byte is ever dropped while in RECV.
- Address end: the strobe at addr = 2^(ROM_DEPTH+1)-1 is the last one. Next cycle -> DONE. No wrap.
- Timeout:
  - timer counts cycles with no rx_valid; it is cleared on each rx_valid.
  - It is active only after at least one byte has been received in the session.
  - When timer reaches TIMEOUT_CYCLES-1 -> DONE.
  - A partial word (byte_idx != 0) is discarded, never written.
- Abort: start falls while in RECV -> IDLE next cycle.
  - A strobe already scheduled for that cycle is suppressed.
  - upg_done is not asserted.
- Simultaneous events:
  - rx_valid and timeout expiry in the same cycle: the byte wins and the timer clears.
  - start fall and 4th byte in the same cycle: abort wins, no write.
- Reset mid-session: immediate return to the reset values. No strobe in the reset cycle.
- Widths: timer width = clog2(TIMEOUT_CYCLES). addr is ROM_DEPTH+1 bits, unsigned.

Decomposition:
- Add to the shared definitions file:
  - UART_LDR_IDLE/RECV/DONE state encodings (2-bit).
  - UART_BYTES_PER_WORD = 4.
  - UART_TIMEOUT default.
- Reuse existing ROM_DEPTH and ISA_WIDTH.
- One natural sub-module: uart_byte_packer. It holds byte_idx, the shadow word and the word_ready pulse.
- The FSM, timer and address counter stay in the top.

Test Plan (ROM_DEPTH=2, TIMEOUT_CYCLES=16):
- start=1, then bytes 0x78,0x56,0x34,0x12 -> one upg_wen pulse 1 cycle after the 4th byte; upg_adr=0, upg_dat=0x12345678; upg_done=0.
- Stream 32 bytes, consecutive rx_valid every cycle -> 8 strobes at upg_adr 0..7, with adr 4..7 having bit2=1 (data memory); upg_done=1 after the 8th; no 9th strobe; start=0 -> IDLE.
- 6 bytes, then silence -> one write at adr 0; after 16 idle cycles upg_done=1; partial bytes 5-6 never written.
- start=1 with no bytes for 100 cycles -> stays in RECV, busy=1, no timeout, no strobe.
- 3 bytes, then start=0 in the same cycle as the 4th byte -> no upg_wen; IDLE; upg_done=0.
- rst pulsed between the 2nd and 3rd words -> all outputs 0 immediately; after release and start, the next word is written at adr 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_pkg
// Description : Shared definitions for the UART programming loader: memory
//               geometry defaults, loader state encodings, word packing and
//               session timeout constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

  // Memory geometry defaults shared with the instruction/data memories
  localparam int UART_ROM_DEPTH      = 14;
  localparam int UART_ISA_WIDTH      = 32;

  // Loader state encodings
  localparam logic [1:0] UART_LDR_IDLE = 2'd0;
  localparam logic [1:0] UART_LDR_RECV = 2'd1;
  localparam logic [1:0] UART_LDR_DONE = 2'd2;

  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_TIMEOUT        = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = UART_LDR_IDLE,
    ST_RECV = UART_LDR_RECV,
    ST_DONE = UART_LDR_DONE
  } ldr_state_t;

endpackage : uart_loader_pkg
`default_nettype wire

// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_if
// Description : Bundle between the UART byte receiver / hazard unit and the
//               memory programming write port.
// Ports       : start, rx_valid, rx_byte      - into the loader
//               upg_wen, upg_adr, upg_dat,
//               upg_done, busy                - out of the loader
//               modport master : loader side
//               modport slave  : environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_loader_if #(
  parameter int ROM_DEPTH = 14,
  parameter int ISA_WIDTH = 32
);
  logic                 start;
  logic                 rx_valid;
  logic [7:0]           rx_byte;
  logic                 upg_wen;
  logic [ROM_DEPTH:0]   upg_adr;
  logic [ISA_WIDTH-1:0] upg_dat;
  logic                 upg_done;
  logic                 busy;

  modport master (
    input  start, rx_valid, rx_byte,
    output upg_wen, upg_adr, upg_dat, upg_done, busy
  );

  modport slave (
    output start, rx_valid, rx_byte,
    input  upg_wen, upg_adr, upg_dat, upg_done, busy
  );
endinterface : uart_loader_if
`default_nettype wire

// File: rtl/uart_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_packer
// Description : Little-endian assembly of four received bytes into one word.
//               Emits a one-cycle word_ready pulse the cycle after the 4th
//               byte; word holds its value until the next completed word.
// Ports       : clk, rst     - clock, async active-high reset
//               clear        - return byte index to 0, drop partial word
//               accept       - rx_byte is taken this cycle
//               rx_byte      - byte to store
//               byte_idx     - index of the next byte within the word
//               word_ready   - pulse, word is complete
//               word         - last completed word
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_packer
  import uart_loader_pkg::*;
#(
  parameter int ISA_WIDTH = UART_ISA_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 clear,
  input  wire logic                 accept,
  input  wire logic [7:0]           rx_byte,
  output logic      [1:0]           byte_idx,
  output logic                      word_ready,
  output logic      [ISA_WIDTH-1:0] word
);

  // Lower three bytes; the top byte goes straight into word on completion
  logic [ISA_WIDTH-9:0] r_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      word_ready <= 1'b0;
      word       <= '0;
      r_shadow   <= '0;
    end else if (clear) begin
      byte_idx   <= 2'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (accept) begin
        if (byte_idx == 2'(UART_BYTES_PER_WORD - 1)) begin
          word       <= {rx_byte, r_shadow};
          word_ready <= 1'b1;
          byte_idx   <= 2'd0;
        end else begin
          r_shadow[{byte_idx, 3'b000} +: 8] <= rx_byte;
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule : uart_byte_packer
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : Producer side of the UART programming write port. Packs
//               received bytes into words and writes them to consecutive
//               word addresses; the address MSB selects data memory.
//               A session ends at the top address, on idle timeout, or is
//               aborted when start drops.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - uart_loader_if.master (start, rx_valid, rx_byte,
//                      upg_wen, upg_adr, upg_dat, upg_done, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ROM_DEPTH      = UART_ROM_DEPTH,
  parameter int ISA_WIDTH      = UART_ISA_WIDTH,
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_loader_if.master bus
);

  localparam int AW     = ROM_DEPTH + 1;
  localparam int TMR_W  = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

  ldr_state_t           r_state, w_next;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        r_adr_out;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_got_byte;  // timeout armed after the first byte
  logic                 r_full;      // last address captured, no more bytes

  logic [1:0]           w_byte_idx;
  logic                 w_word_ready;
  logic [ISA_WIDTH-1:0] w_word;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_timeout;

  assign w_accept  = (r_state == ST_RECV) && bus.start && bus.rx_valid && !r_full;
  assign w_capture = w_accept && (w_byte_idx == 2'(UART_BYTES_PER_WORD - 1));
  // A byte in the expiry cycle wins over the timeout
  assign w_timeout = r_got_byte && !bus.rx_valid &&
                     (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  uart_byte_packer #(.ISA_WIDTH(ISA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (r_state != ST_RECV),
    .accept     (w_accept),
    .rx_byte    (bus.rx_byte),
    .byte_idx   (w_byte_idx),
    .word_ready (w_word_ready),
    .word       (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RECV;
      ST_RECV: begin
        if (!bus.start)                  w_next = ST_IDLE;
        else if (w_word_ready && r_full) w_next = ST_DONE;
        else if (w_timeout)              w_next = ST_DONE;
      end
      ST_DONE: if (!bus.start) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_adr_out  <= '0;
      r_timer    <= '0;
      r_got_byte <= 1'b0;
      r_full     <= 1'b0;
    end else if (r_state != ST_RECV) begin
      r_addr     <= '0;
      r_timer    <= '0;
      r_got_byte <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_adr_out <= r_addr;
        r_addr    <= r_addr + AW'(1);
        if (r_addr == {AW{1'b1}}) r_full <= 1'b1;
      end
      if (w_accept) begin
        r_timer    <= '0;
        r_got_byte <= 1'b1;
      end else if (r_got_byte) begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  // Dropping start during the strobe cycle suppresses the write
  assign bus.upg_wen  = w_word_ready && bus.start && (r_state == ST_RECV);
  assign bus.upg_adr  = r_adr_out;
  assign bus.upg_dat  = w_word;
  assign bus.upg_done = (r_state == ST_DONE);
  assign bus.busy     = (r_state == ST_RECV);

endmodule : uart_loader
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Self-checking bench for uart_loader (ROM_DEPTH=2,
//               TIMEOUT_CYCLES=16). Expected writes are queued by the
//               stimulus and consumed by an independent strobe monitor.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  localparam int RD = 2;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [RD:0]   adr;
    logic [IW-1:0] dat;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  uart_loader_if #(.ROM_DEPTH(RD), .ISA_WIDTH(IW)) bus ();

  uart_loader #(.ROM_DEPTH(RD), .ISA_WIDTH(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.upg_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got wen=%b adr=%0h dat=%08h expected no write",
                 bus.upg_wen, bus.upg_adr, bus.upg_dat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_adr", 32'(bus.upg_adr), 32'(e.adr));
        check("strobe_dat", bus.upg_dat, e.dat);
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Four bytes little-endian; the strobe is due in the cycle right after the 4th
  task automatic send_word(input logic [RD:0] adr, input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    e.adr = adr;
    e.dat = w;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic done, input logic busy);
    check({tag, "_done"}, 32'(bus.upg_done), 32'(done));
    check({tag, "_busy"}, 32'(bus.busy), 32'(busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    tick();
    tick();
    check("reset_wen", 32'(bus.upg_wen), 32'd0);
    check("reset_adr", 32'(bus.upg_adr), 32'd0);
    check("reset_dat", bus.upg_dat, 32'd0);
    check_status("reset", 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Single word at address 0
    bus.start = 1'b1;
    tick();
    check_status("t1_start", 1'b0, 1'b1);
    send_word(3'd0, 32'h12345678);
    repeat (3) tick();
    check_status("t1_after", 1'b0, 1'b1);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    bus.start = 1'b0;
    repeat (2) tick();
    check_status("t1_idle", 1'b0, 1'b0);

    // Full address space, back-to-back bytes; bit2 marks data memory
    bus.start = 1'b1;
    tick();
    for (int w = 0; w < 8; w++) send_word(3'(w), 32'hA5000000 + 32'(w * 32'h01010101));
    repeat (2) tick();
    check_status("t2_full", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hEE);   // must not produce a 9th write
    repeat (2) tick();
    check_status("t2_hold", 1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (2) tick();
    check_status("t2_idle", 1'b0, 1'b0);

    // One word plus a partial word, then silence until timeout
    bus.start = 1'b1;
    tick();
    send_word(3'd0, 32'hCAFEF00D);
    send(8'h11);
    send(8'h22);
    repeat (14) tick();
    check_status("t3_wait", 1'b0, 1'b1);
    repeat (4) tick();
    check_status("t3_timeout", 1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (2) tick();

    // No bytes: timeout is not armed
    bus.start = 1'b1;
    repeat (100) tick();
    check_status("t4_no_bytes", 1'b0, 1'b1);
    bus.start = 1'b0;
    repeat (2) tick();
    check_status("t4_idle", 1'b0, 1'b0);

    // Abort together with the 4th byte
    bus.start = 1'b1;
    tick();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h04;
    tick();
    bus.rx_valid = 1'b0;
    repeat (3) tick();
    check_status("t5_abort", 1'b0, 1'b0);

    // Reset in the middle of the third word
    bus.start = 1'b1;
    tick();
    send_word(3'd0, 32'h01020304);
    send_word(3'd1, 32'hDEADBEEF);
    send(8'h55);
    send(8'h66);
    rst = 1'b1;
    #1;
    check("t6_rst_adr", 32'(bus.upg_adr), 32'd0);
    check("t6_rst_dat", bus.upg_dat, 32'd0);
    check_status("t6_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    send_word(3'd0, 32'h0BADBEEF);
    repeat (3) tick();
    bus.start = 1'b0;
    repeat (2) tick();

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_loader
`default_nettype wire
